// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end: datapath widths, opcodes that
// the fetch stage cares about, interrupt vector addresses and the fetch
// state encodings.
package cpu_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] OP_HALT = 8'h98;
   localparam logic [DATA_W-1:0] OP_RETI = 8'h32;
   localparam logic [DATA_W-1:0] OP_JNZ  = 8'h70;

   localparam logic [ADDR_W-1:0] VEC_RESET = 16'h0000;
   localparam logic [ADDR_W-1:0] VEC_TF0   = 16'h000B;

   typedef enum logic [1:0] {
      FETCH_RUN  = 2'b00,
      FETCH_HALT = 2'b01
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: byte-wide prefetch FIFO. Accepts one byte per push and
// releases two bytes (one instruction) per pop. Both head bytes are read
// combinationally and forced to zero until a full instruction is held, so
// unwritten storage never reaches the decoder.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (empties the queue)
//   flush      empty the queue at the next edge (wins over push/pop)
//   push       write push_byte at the tail (ignored when full)
//   push_byte  byte to write
//   pop        drop the two head bytes (ignored with fewer than two)
//   count      bytes currently held
//   head_byte  byte at the head
//   next_byte  byte after the head
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_byte,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] head_byte,
   output logic [DATA_W-1:0] next_byte
);

   localparam int PTR_W = $clog2(QDEPTH);

   logic [DATA_W-1:0] mem_q [QDEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_p1;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;
   logic              has_instr;

   // QDEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int n);
      int s;
      s = int'(p) + n;
      if (s >= QDEPTH) s = s - QDEPTH;
      return PTR_W'(s);
   endfunction

   assign has_instr = (count_q >= CNT_W'(2));
   assign do_push   = push && (count_q < CNT_W'(QDEPTH));
   assign do_pop    = pop && has_instr;
   assign rd_ptr_p1 = ptr_add(rd_ptr_q, 1);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_add(wr_ptr_q, 1);
         if (do_pop)  rd_ptr_q <= ptr_add(rd_ptr_q, 2);
         count_q <= count_q + CNT_W'(do_push) - (do_pop ? CNT_W'(2) : CNT_W'(0));
      end
   end

   // Storage carries no reset; contents are only visible through has_instr.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_byte;
   end

   assign count     = count_q;
   assign head_byte = has_instr ? mem_q[rd_ptr_q]  : '0;
   assign next_byte = has_instr ? mem_q[rd_ptr_p1] : '0;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program-memory fetch stage. Streams bytes from the
// combinational ROM into a prefetch queue and hands complete two-byte
// instructions (opcode + operand) to the decoder over valid/ready.
// Redirects reload both the fetch and head addresses and flush the queue;
// accepting the HALT opcode stops fetching until the next redirect.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   rom_en          ROM read enable (a byte is captured whenever high)
//   rom_addr        ROM byte address (fetch PC)
//   rom_byte        ROM data, combinational from rom_addr
//   redirect_valid  load redirect_addr as the new fetch address
//   redirect_addr   new fetch address
//   instr_valid     a complete instruction sits at the queue head
//   instr_ready     decoder accepts the instruction
//   instr_opcode    head byte
//   instr_operand   byte after the head
//   instr_pc        address of instr_opcode
//   halted          fetch stopped by the HALT opcode
//
// state      | meaning
// -----------+-------------------------------------------------------
// FETCH_RUN  | fetching whenever the queue has room
// FETCH_HALT | HALT accepted; no fetch until redirect_valid
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h003B,
   parameter int                QDEPTH   = 4,
   parameter logic [DATA_W-1:0] HALT_OP  = OP_HALT
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_byte,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_opcode,
   output logic [DATA_W-1:0] instr_operand,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);

   localparam int CNT_W = $clog2(QDEPTH + 1);

   fetch_state_t      state_q;
   fetch_state_t      state_nxt;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] head_pc_q;
   logic [CNT_W-1:0]  q_count;
   logic              push;
   logic              pop;
   logic              halt_pop;
   logic              flush;

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .CNT_W  (CNT_W)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_byte (rom_byte),
      .pop       (pop),
      .count     (q_count),
      .head_byte (instr_opcode),
      .next_byte (instr_operand)
   );

   assign halted = (state_q == FETCH_HALT);

   // Room is judged on the current count only; a same-cycle pop does not
   // make space for this cycle's fetch.
   assign rom_en = rst_n && !halted && !redirect_valid &&
                   (q_count < CNT_W'(QDEPTH));
   assign push   = rom_en;

   assign instr_valid = (q_count >= CNT_W'(2));
   assign pop         = instr_valid && instr_ready;
   assign halt_pop    = pop && (instr_opcode == HALT_OP);

   // A pop coinciding with a redirect is seen by the decoder, but the flush
   // discards its effect on the queue.
   assign flush = redirect_valid || halt_pop;

   assign rom_addr = fetch_pc_q;
   assign instr_pc = head_pc_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH_RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         FETCH_RUN:  if (!redirect_valid && halt_pop) state_nxt = FETCH_HALT;
         FETCH_HALT: if (redirect_valid)              state_nxt = FETCH_RUN;
         default:                                     state_nxt = FETCH_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         head_pc_q  <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc_q <= redirect_addr;
         head_pc_q  <= redirect_addr;
      end else begin
         if (push) fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
         if (pop)  head_pc_q  <= head_pc_q + ADDR_W'(2);
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rom_en;
   logic [15:0] rom_addr;
   logic [7:0]  rom_byte;
   logic        redirect_valid;
   logic [15:0] redirect_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic [7:0]  instr_operand;
   logic [15:0] instr_pc;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [15:0] pc;
      logic [7:0]  op;
      logic [7:0]  opd;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_fn(input logic [15:0] a);
      case (a)
         16'h003B: return 8'h74;
         16'h003C: return 8'h01;
         16'h000B: return 8'hE9;
         16'h0003: return 8'h74;
         16'h0055: return 8'h98;
         default:  return a[7:0] + 8'h11;
      endcase
   endfunction

   function automatic exp_t exp_at(input logic [15:0] pc);
      exp_t e;
      e.pc  = pc;
      e.op  = rom_fn(pc);
      e.opd = rom_fn(pc + 16'd1);
      return e;
   endfunction

   assign rom_byte = rom_fn(rom_addr);

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_byte       (rom_byte),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_opcode   (instr_opcode),
      .instr_operand  (instr_operand),
      .instr_pc       (instr_pc),
      .halted         (halted)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic ready);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 16'h0000;
      instr_ready = ready;
      tick();
      tick();
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic wait_accept(input int budget, output int waited, output bit timed_out);
      waited = 0;
      timed_out = 1'b1;
      while (waited < budget) begin
         tick();
         waited++;
         if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = 16'h0000; instr_ready = 1'b1;
      tick(); tick();
      n_tests++;
      if ({rom_en, instr_valid, halted} !== 3'b000) begin
         n_fail++; $display("FAIL reset_ctrl: rom_en/valid/halted=%b required 000", {rom_en, instr_valid, halted});
      end
      n_tests++;
      if (instr_opcode !== 8'h00 || instr_operand !== 8'h00) begin
         n_fail++; $display("FAIL reset_data: op/opd=%h/%h required 00/00", instr_opcode, instr_operand);
      end
      n_tests++;
      if (instr_pc !== 16'h003B || rom_addr !== 16'h003B) begin
         n_fail++; $display("FAIL reset_pc: instr_pc/rom_addr=%h/%h required 003b/003b", instr_pc, rom_addr);
      end
      rst_n = 1'b1;
      sb.delete();
      sb.push_back(exp_at(16'h003B));
      #1;
      n_tests++;
      if (rom_en !== 1'b1) begin
         n_fail++; $display("FAIL first_fetch_en: rom_en=%b required 1", rom_en);
      end
      tick();
      n_tests++;
      if (rom_addr !== 16'h003C || instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL cycle1: rom_addr/valid=%h/%b required 003c/0", rom_addr, instr_valid);
      end
      tick();
      n_tests++;
      if (instr_valid !== 1'b1) begin
         n_fail++; $display("FAIL cycle2_valid: instr_valid=%b required 1", instr_valid);
      end
      e = sb.pop_front();
      n_tests++;
      if ({instr_pc, instr_opcode, instr_operand} !== e) begin
         n_fail++; $display("FAIL first_instr: got %h required %h", {instr_pc, instr_opcode, instr_operand}, e);
      end
   endtask

   task automatic test_fill();
      exp_t e;
      do_reset(1'b0);
      repeat (4) tick();
      n_tests++;
      if (rom_en !== 1'b0 || rom_addr !== 16'h003F || instr_valid !== 1'b1) begin
         n_fail++; $display("FAIL fill_full: rom_en/rom_addr/valid=%b/%h/%b required 0/003f/1", rom_en, rom_addr, instr_valid);
      end
      tick();
      n_tests++;
      if (rom_en !== 1'b0 || rom_addr !== 16'h003F) begin
         n_fail++; $display("FAIL fill_hold: rom_en/rom_addr=%b/%h required 0/003f", rom_en, rom_addr);
      end
      sb.push_back(exp_at(16'h003B));
      sb.push_back(exp_at(16'h003D));
      instr_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         e = sb.pop_front();
         n_tests++;
         if (instr_valid !== 1'b1 || {instr_pc, instr_opcode, instr_operand} !== e) begin
            n_fail++; $display("FAIL fill_pop%0d: valid=%b got %h required %h", i, instr_valid, {instr_pc, instr_opcode, instr_operand}, e);
         end
         tick();
      end
      n_tests++;
      if (rom_en !== 1'b1 || rom_addr !== 16'h0040) begin
         n_fail++; $display("FAIL fill_resume: rom_en/rom_addr=%b/%h required 1/0040", rom_en, rom_addr);
      end
   endtask

   task automatic test_redirect();
      exp_t e;
      int   w;
      bit   to;
      do_reset(1'b0);
      repeat (3) tick();
      n_tests++;
      if (instr_valid !== 1'b1 || rom_addr !== 16'h003E) begin
         n_fail++; $display("FAIL redir_pre: valid/rom_addr=%b/%h required 1/003e", instr_valid, rom_addr);
      end
      redirect_valid = 1'b1; redirect_addr = 16'h000B;
      #1;
      n_tests++;
      if (rom_en !== 1'b0) begin
         n_fail++; $display("FAIL redir_rom_en: rom_en=%b required 0", rom_en);
      end
      tick();
      redirect_valid = 1'b0;
      n_tests++;
      if (instr_valid !== 1'b0 || rom_addr !== 16'h000B) begin
         n_fail++; $display("FAIL redir_flush: valid/rom_addr=%b/%h required 0/000b", instr_valid, rom_addr);
      end
      instr_ready = 1'b1;
      sb.push_back(exp_at(16'h000B));
      wait_accept(4, w, to);
      e = sb.pop_front();
      n_tests++;
      if (to || w != 2 || {instr_pc, instr_opcode, instr_operand} !== e || instr_opcode !== 8'hE9) begin
         n_fail++; $display("FAIL redir_first: timeout=%0d cycles=%0d got %h required %h after 2 cycles", to, w, {instr_pc, instr_opcode, instr_operand}, e);
      end
   endtask

   task automatic test_halt();
      exp_t e;
      int   w;
      bit   to;
      bit   bad;
      do_reset(1'b1);
      redirect_valid = 1'b1; redirect_addr = 16'h0055;
      tick();
      redirect_valid = 1'b0;
      sb.push_back(exp_at(16'h0055));
      wait_accept(4, w, to);
      e = sb.pop_front();
      n_tests++;
      if (to || {instr_pc, instr_opcode, instr_operand} !== e) begin
         n_fail++; $display("FAIL halt_instr: timeout=%0d got %h required %h", to, {instr_pc, instr_opcode, instr_operand}, e);
      end
      tick();
      n_tests++;
      if (halted !== 1'b1 || rom_en !== 1'b0 || instr_valid !== 1'b0) begin
         n_fail++; $display("FAIL halt_enter: halted/rom_en/valid=%b/%b/%b required 1/0/0", halted, rom_en, instr_valid);
      end
      bad = 1'b0;
      repeat (22) begin
         tick();
         if (halted !== 1'b1 || rom_en !== 1'b0 || instr_valid !== 1'b0) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
         n_fail++; $display("FAIL halt_hold: halted/rom_en/valid left 1/0/0 during hold, now %b/%b/%b", halted, rom_en, instr_valid);
      end
      redirect_valid = 1'b1; redirect_addr = 16'h0003;
      tick();
      redirect_valid = 1'b0;
      n_tests++;
      if (halted !== 1'b0 || rom_addr !== 16'h0003) begin
         n_fail++; $display("FAIL halt_exit: halted/rom_addr=%b/%h required 0/0003", halted, rom_addr);
      end
      sb.push_back(exp_at(16'h0003));
      wait_accept(4, w, to);
      e = sb.pop_front();
      n_tests++;
      if (to || {instr_pc, instr_opcode, instr_operand} !== e) begin
         n_fail++; $display("FAIL halt_resume: timeout=%0d got %h required %h", to, {instr_pc, instr_opcode, instr_operand}, e);
      end
   endtask

   task automatic test_wrap();
      exp_t e;
      int   w;
      bit   to;
      do_reset(1'b1);
      redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
      tick();
      redirect_valid = 1'b0;
      n_tests++;
      if (rom_addr !== 16'hFFFF) begin
         n_fail++; $display("FAIL wrap_addr0: rom_addr=%h required ffff", rom_addr);
      end
      tick();
      n_tests++;
      if (rom_addr !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_addr1: rom_addr=%h required 0000", rom_addr);
      end
      sb.push_back(exp_at(16'hFFFF));
      sb.push_back(exp_at(16'h0001));
      for (int i = 0; i < 2; i++) begin
         wait_accept(4, w, to);
         e = sb.pop_front();
         n_tests++;
         if (to || {instr_pc, instr_opcode, instr_operand} !== e) begin
            n_fail++; $display("FAIL wrap_instr%0d: timeout=%0d got %h required %h", i, to, {instr_pc, instr_opcode, instr_operand}, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   w;
      bit   to;
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) sb.push_back(exp_at(16'h003B + 16'(2 * i)));
      for (int i = 0; i < 6; i++) begin
         wait_accept(4, w, to);
         e = sb.pop_front();
         n_tests++;
         if (to || w != 2 || {instr_pc, instr_opcode, instr_operand} !== e) begin
            n_fail++; $display("FAIL b2b%0d: timeout=%0d gap=%0d got %h required %h gap 2", i, to, w, {instr_pc, instr_opcode, instr_operand}, e);
         end
      end
      // valid and ready are high here: redirect in the same cycle as a pop
      redirect_valid = 1'b1; redirect_addr = 16'h0040;
      tick();
      redirect_valid = 1'b0;
      n_tests++;
      if (instr_valid !== 1'b0 || instr_pc !== 16'h0040) begin
         n_fail++; $display("FAIL redir_pop: valid/instr_pc=%b/%h required 0/0040", instr_valid, instr_pc);
      end
      sb.push_back(exp_at(16'h0040));
      wait_accept(4, w, to);
      e = sb.pop_front();
      n_tests++;
      if (to || {instr_pc, instr_opcode, instr_operand} !== e) begin
         n_fail++; $display("FAIL redir_pop_next: timeout=%0d got %h required %h", to, {instr_pc, instr_opcode, instr_operand}, e);
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   w;
      bit   to;
      do_reset(1'b0);
      redirect_valid = 1'b1; redirect_addr = 16'h0020;
      tick();
      redirect_valid = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (instr_valid !== 1'b1 || rom_addr !== 16'h0023) begin
         n_fail++; $display("FAIL mid_pre: valid/rom_addr=%b/%h required 1/0023", instr_valid, rom_addr);
      end
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (instr_valid !== 1'b0 || halted !== 1'b0 || rom_addr !== 16'h003B || rom_en !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: valid/halted/rom_addr/rom_en=%b/%b/%h/%b required 0/0/003b/0", instr_valid, halted, rom_addr, rom_en);
      end
      rst_n = 1'b1;
      instr_ready = 1'b1;
      sb.delete();
      sb.push_back(exp_at(16'h003B));
      sb.push_back(exp_at(16'h003D));
      for (int i = 0; i < 2; i++) begin
         wait_accept(4, w, to);
         e = sb.pop_front();
         n_tests++;
         if (to || {instr_pc, instr_opcode, instr_operand} !== e) begin
            n_fail++; $display("FAIL mid_after%0d: timeout=%0d got %h required %h", i, to, {instr_pc, instr_opcode, instr_operand}, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr = 16'h0000;
      instr_ready = 1'b0;
      test_reset();
      test_fill();
      test_redirect();
      test_halt();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-memory fetch stage between the program counter and the instruction decoder.
- Drives the ROM's enable and address, reads its combinational byte output, and buffers bytes in a small prefetch queue.
- Presents complete 2-byte instructions (opcode + operand) to the decoder over a valid/ready handshake.
- Handles redirects (jumps, interrupt vectors, RETI) and the HALT opcode.

Parameters:
- RESET_PC, 16'h003B: fetch address after reset.
- QDEPTH, 4: prefetch queue depth in bytes; must be an even number ≥ 2.
- HALT_OP, 8'h98: opcode that stops fetching once accepted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rom_en  output  1  ROM read enable.
- rom_addr  output  16  ROM byte address (fetch PC).
- rom_byte  input  8  ROM data, combinational from rom_addr.
- redirect_valid  input  1  load a new fetch address (jump/vector/RETI).
- redirect_addr  input  16  new fetch address.
- instr_valid  output  1  a complete instruction is at the queue head.
- instr_ready  input  1  decoder accepts the instruction.
- instr_opcode  output  8  head byte.
- instr_operand  output  8  byte after the head.
- instr_pc  output  16  address of instr_opcode.
- halted  output  1  fetch stopped by HALT_OP.

Behaviour:
- Reset (rst_n=0 at an edge):
  - fetch_pc = RESET_PC, head_pc = RESET_PC.
  - Queue count = 0, halted = 0.
  - Outputs: rom_en=0 during reset, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=RESET_PC.
  - Reset mid-operation discards queue contents and any pending redirect.
- rom_en = !halted && count < QDEPTH && !redirect_valid. rom_addr = fetch_pc at all times.
- push = rom_en. On push, rom_byte is written at the queue tail and fetch_pc increments by 1, wrapping 16'hFFFF to 16'h0000.
- instr_valid = (count ≥ 2), combinational from registered queue state.
- instr_opcode/instr_operand = queue[head], queue[head+1]; both are 0 when count < 2.
- pop = instr_valid && instr_ready. On pop, head advances by 2 (mod QDEPTH) and head_pc += 2 (16-bit wrap).
- Simultaneous push and pop: count_next = count + 1 − 2. The push decision uses the current count only; the pop does not free space in the same cycle.
- Latency: first instr_valid appears 2 cycles after the first edge with rst_n=1 (one byte per cycle). Sustained throughput is one instruction per 2 cycles.
- Redirect has the highest priority:
  - At the edge: queue flushed (count=0), fetch_pc = head_pc = redirect_addr, halted cleared.
  - A pop presented in the same cycle is still honoured by the decoder side, but its queue effect is discarded.
  - instr_valid is 0 in the following cycle.
- Halt: when pop occurs with instr_opcode == HALT_OP, halted=1 at that edge and the queue is flushed. rom_en stays 0 until redirect_valid or reset.
- States (2-bit): RUN, HALT.
  - RUN→HALT on an accepted HALT_OP.
  - HALT→RUN on redirect_valid.
  - Reset→RUN.
- No x propagation: unfilled queue entries are never presented.

Decomposition:
- Shared package (cpu_pkg), constants only:
  - Opcodes: OP_HALT=8'h98, OP_RETI=8'h32, OP_JNZ=8'h70.
  - Interrupt vectors: VEC_RESET, VEC_TF0.
  - ADDR_W=16, DATA_W=8, fetch-state encodings.
- One sub-module: fetch_queue. Byte FIFO with 1-byte push, 2-byte pop, flush, count output, two head-read ports. Parameterised by QDEPTH.
- Top module holds fetch_pc, head_pc, the state register and the ROM handshake.

Test Plan:
- Reset with ROM[59]=8'h74, ROM[60]=8'h01, instr_ready=1:
  - rom_addr = 16'h003B, then 16'h003C.
  - instr_valid asserts in cycle 2 with opcode 8'h74, operand 8'h01, instr_pc 16'h003B.
- instr_ready=0 from reset:
  - Queue fills to 4 bytes; rom_en drops after 4 pushes; rom_addr holds 16'h003F.
  - Release ready: two instructions pop on consecutive opportunities (instr_pc 16'h003B, then 16'h003D); fetch resumes.
- redirect_valid with redirect_addr=16'h000B while queue holds 3 bytes:
  - Next cycle: instr_valid=0, rom_addr=16'h000B.
  - Two cycles later: opcode = ROM[11] = 8'hE9, instr_pc = 16'h000B.
- Accept opcode 8'h98 at 16'h0055:
  - halted=1 and rom_en=0 for 20+ cycles.
  - redirect_valid to 16'h0003 clears halted; instr_pc = 16'h0003, opcode 8'h74.
- redirect_addr=16'hFFFF:
  - Bytes fetched from 16'hFFFF, then 16'h0000.
  - instr_pc 16'hFFFF; the next accepted instr_pc is 16'h0001.
- Assert rst_n=0 mid-stream with count=3, hold one cycle:
  - instr_valid=0, halted=0, rom_addr=16'h003B, no stale bytes delivered afterward.
